// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef logic [3:0] bcd_nibble_t;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t CONV   = 2'd1;
   localparam state_t COMMIT = 2'd2;

   // Largest value representable in num_digits decimal digits (10^n - 1).
   function automatic logic [63:0] bcd_max(input int unsigned num_digits);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < num_digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Handshaked, saturating binary-to-BCD converter (one double-dabble step per cycle).
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BIN_W-1:0]        value_in,
   input  logic                    value_valid,
   output logic                    value_ready,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    overflow
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [63:0] MAX_VAL = bcd_max(NUM_DIGITS);
   localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(MAX_VAL);

   state_t           state, state_d;
   logic [CNT_W-1:0] count, count_d;
   logic [BIN_W-1:0] bin_sh, bin_d;
   logic [BCD_W-1:0] work, work_d;
   logic [BCD_W-1:0] adj;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;

   // Next-state and datapath for the IDLE -> CONV -> COMMIT sequence.
   always_comb begin
      state_d = state;
      count_d = count;
      bin_d   = bin_sh;
      work_d  = work;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      adj     = work;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
      case (state)
         IDLE: begin
            if (value_valid && ready_q) begin
               state_d = CONV;
               count_d = CNT_W'(BIN_W);
               work_d  = '0;
               if (64'(value_in) > MAX_VAL) begin
                  bin_d = SAT_VAL;
                  ovf_d = 1'b1;
               end else begin
                  bin_d = value_in;
                  ovf_d = 1'b0;
               end
            end
         end
         CONV: begin
            work_d  = BCD_W'({adj, bin_sh[BIN_W-1]});
            bin_d   = bin_sh << 1;
            count_d = count - CNT_W'(1);
            if (count == CNT_W'(1)) state_d = COMMIT;
         end
         COMMIT: begin
            bcd_d   = work;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         bin_sh  <= '0;
         work    <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_d;
         count   <= count_d;
         bin_sh  <= bin_d;
         work    <= work_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   assign value_ready = ready_q;
   assign bcd         = bcd_q;
   assign overflow    = ovf_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Binary value to time-multiplexed BCD digit bus with active-low anode selects.
// Optional leading-zero blanking when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned BIN_W       = 16,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      value_in,
   input  logic                  value_valid,
   output logic                  value_ready,
   output logic [3:0]            digit,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  overflow
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [BCD_W-1:0]      disp;
   logic [CNT_W-1:0]      refresh_cnt, cnt_d;
   logic [IDX_W-1:0]      scan_idx, idx_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   bcd_nibble_t           digit_q, digit_d;
   bcd_nibble_t           nib;
   logic                  wrap;
   logic                  blank;
`ifdef SEG_SCAN_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;
   logic                  zero_run;
`endif

   bin2bcd_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .BIN_W      (BIN_W)
   ) u_conv (
      .clk         (clk),
      .rst         (rst),
      .value_in    (value_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .bcd         (disp),
      .overflow    (overflow)
   );

   // Anode and digit are computed from the same next index so they switch together.
   always_comb begin
      wrap  = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
      cnt_d = wrap ? '0 : refresh_cnt + CNT_W'(1);
      idx_d = scan_idx;
      if (wrap) idx_d = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      an_d  = '1;
      nib   = '0;
      blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
      lz       = '0;
      zero_run = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
         lz[i]    = zero_run;
      end
`endif
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            an_d[i] = 1'b0;
            nib     = disp[4*i +: 4];
`ifdef SEG_SCAN_LZ_BLANK_EN
            blank   = lz[i] && (i != 0);
`endif
         end
      end
      digit_d = blank ? BLANK_CODE : nib;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
         an_q        <= ~NUM_DIGITS'(1);
         digit_q     <= '0;
      end else begin
         refresh_cnt <= cnt_d;
         scan_idx    <= idx_d;
         an_q        <= an_d;
         digit_q     <= digit_d;
      end
   end

   assign an    = an_q;
   assign digit = digit_q;

endmodule
